// File: rtl/dm_bus_responder_pkg.sv
// Shared types and constants for the data-memory bus responder.
package dm_bus_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEFAULT_DEPTH_WORDS = 3072;

   localparam int NUM_LEGAL_BE = 7;
   localparam logic [NUM_LEGAL_BE-1:0][3:0] LEGAL_BE = {
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
   };

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] pc;
   } req_t;

   function automatic logic be_legal(input logic [3:0] be);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < NUM_LEGAL_BE; i++)
         ok = ok | (LEGAL_BE[i] == be);
      return ok;
   endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Byte-lane merge: enabled lanes come from wdata, the rest from the old word.
module dm_lane_merge #(
   parameter int NUM_LANES = 4,
   parameter int LANE_W    = 8
) (
   input  logic [NUM_LANES-1:0][LANE_W-1:0] old_word,
   input  logic [NUM_LANES-1:0][LANE_W-1:0] wdata,
   input  logic [NUM_LANES-1:0]             be,
   output logic [NUM_LANES-1:0][LANE_W-1:0] merged
);

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      assign merged[l] = be[l] ? wdata[l] : old_word[l];
   end

endmodule

// File: rtl/dm_bus_responder.sv
// Data-memory responder: one outstanding request, programmable latency,
// byte-lane stores, range and byte-enable error detection.
module dm_bus_responder
   import dm_bus_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_t      state;
   logic [3:0]  cnt;
   req_t        req_q, req_in, cur;
   logic [31:0] mem [DEPTH_WORDS];

   logic [29:0]      word_idx;
   logic [IDX_W-1:0] mem_idx;
   logic [3:0]       eff_be;
   logic             oor, err, commit;
   logic [31:0]      rd_word, merged;
   logic             unused_addr_bits;

   assign req_in = '{we: req_we, addr: req_addr, be: req_be, wdata: req_wdata, pc: req_pc};

   // With zero wait the commit happens on the accept edge, before req_q is loaded.
   assign cur      = (state == IDLE) ? req_in : req_q;
   assign word_idx = cur.addr[31:2];
   assign mem_idx  = cur.addr[IDX_W+1:2];
   assign unused_addr_bits = ^cur.addr[1:0];

   assign eff_be = (!cur.we && cur.be == 4'b0000) ? 4'b1111 : cur.be;
   assign oor    = {2'b00, word_idx} >= 32'(DEPTH_WORDS);
   assign err    = oor || !be_legal(eff_be);
   assign rd_word = mem[mem_idx];

   assign commit = (state == IDLE && req_valid && WAIT_CYCLES == 0) ||
                   (state == WAIT && cnt == 4'd1);

   dm_lane_merge u_merge (
      .old_word (rd_word),
      .wdata    (cur.wdata),
      .be       (cur.be),
      .merged   (merged)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
         req_q     <= '0;
         for (int i = 0; i < DEPTH_WORDS; i++)
            mem[i] <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               req_q     <= req_in;
               cnt       <= 4'(WAIT_CYCLES);
               req_ready <= 1'b0;
               state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= RESP;
            end
            RESP: if (rsp_ready) begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase

         if (commit) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || cur.we) ? 32'h0 : rd_word;
            if (cur.we && !err) begin
               mem[mem_idx] <= merged;
`ifndef SYNTHESIS
               $display("@%08h: *%08h <= %08h", cur.pc, {cur.addr[31:2], 2'b00}, merged);
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_dm_bus_responder.sv
// Directed bench: vector table on a WAIT_CYCLES=2 instance, plus hand
// sequences for back-to-back zero-wait traffic, response hold and mid-wait reset.
module tb_dm_bus_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, req_wdata, req_pc, rsp_rdata;
   logic [3:0]  req_be;

   logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
   logic [31:0] req_addr0, req_wdata0, req_pc0, rsp_rdata0;
   logic [3:0]  req_be0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dm_bus_responder #(.WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_pc(req_pc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dm_bus_responder #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
      .req_addr(req_addr0), .req_be(req_be0), .req_wdata(req_wdata0), .req_pc(req_pc0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 50);
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] pc,
                         output logic [31:0] rdata, output logic err, output int lat);
      @(negedge clk);
      req_we = we; req_addr = addr; req_be = be; req_wdata = wdata; req_pc = pc;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp(lat);
      rdata = rsp_rdata;
      err   = rsp_err;
      if (rsp_valid) begin
         rsp_ready = 1'b1;
         @(posedge clk);
         #1 rsp_ready = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      vecs[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h0, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'h1234_5678, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0010, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'h1234_AB78, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_3000, 4'b1111, 32'h0,         32'h0, 1'b1};
      vecs[5]  = '{1'b1, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b1};
      vecs[6]  = '{1'b0, 32'h0000_2FFC, 4'b1111, 32'h0,         32'h0, 1'b0};
      vecs[7]  = '{1'b1, 32'h0000_0010, 4'b0101, 32'hFFFF_FFFF, 32'h0, 1'b1};
      vecs[8]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'h1234_AB78, 1'b0};
      vecs[9]  = '{1'b0, 32'h0000_0013, 4'b0000, 32'h0,         32'h1234_AB78, 1'b0};
      vecs[10] = '{1'b1, 32'h0000_0014, 4'b0000, 32'h5555_5555, 32'h0, 1'b1};
      vecs[11] = '{1'b0, 32'h0000_0014, 4'b1111, 32'h0,         32'h0, 1'b0};
      vecs[12] = '{1'b1, 32'h0000_2FFC, 4'b1100, 32'hCAFE_0000, 32'h0, 1'b0};
      vecs[13] = '{1'b0, 32'h0000_2FFC, 4'b0011, 32'h0,         32'hCAFE_0000, 1'b0};
      vecs[14] = '{1'b0, 32'h0000_0010, 4'b0110, 32'h0,         32'h0, 1'b1};

      reset = 1'b1;
      req_valid = 0; req_we = 0; req_addr = 0; req_be = 0; req_wdata = 0; req_pc = 0; rsp_ready = 0;
      req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_be0 = 0; req_wdata0 = 0; req_pc0 = 0; rsp_ready0 = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'h0);
      chk("reset_rsp_err",   32'(rsp_err), 32'd0);

      for (int i = 0; i < 15; i++) begin
         do_req(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, 32'h3000 + 32'(i * 4), rd, er, lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      end

      // Zero-wait instance: back-to-back store then load with rsp_ready held high.
      @(negedge clk);
      rsp_ready0 = 1'b1;
      req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h8; req_be0 = 4'b1111;
      req_wdata0 = 32'hA5A5_A5A5; req_pc0 = 32'h4000;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("w0_req_ready_c%0d", c), 32'(req_ready0), 32'(c % 2 == 0));
         chk($sformatf("w0_rsp_valid_c%0d", c), 32'(rsp_valid0), 32'(c % 2 == 1));
         if (c == 1) begin
            chk("w0_store_err", 32'(rsp_err0), 32'd0);
            req_we0 = 1'b0; req_wdata0 = 32'h0;
         end
         if (c == 3) begin
            chk("w0_load_rdata", rsp_rdata0, 32'hA5A5_A5A5);
            req_valid0 = 1'b0;
         end
      end
      @(posedge clk);
      #1 rsp_ready0 = 1'b0;

      // Response held for 5 cycles without rsp_ready; a stray request meanwhile is ignored.
      @(negedge clk);
      req_we = 1'b0; req_addr = 32'h10; req_be = 4'b1111; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp(lat);
      chk("hold_latency", 32'(lat), 32'd3);
      req_we = 1'b1; req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("hold_valid_c%0d", c), 32'(rsp_valid), 32'd1);
         chk($sformatf("hold_rdata_c%0d", c), rsp_rdata, 32'h1234_AB78);
         chk($sformatf("hold_err_c%0d", c), 32'(rsp_err), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      do_req(1'b0, 32'h10, 4'b1111, 32'h0, 32'h0, rd, er, lat);
      chk("stray_ignored_rdata", rd, 32'h1234_AB78);

      // Reset while a store sits in WAIT: store discarded, array cleared.
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h40; req_be = 4'b1111; req_wdata = 32'h1111_1111;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("pre_reset_in_wait", 32'(req_ready), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      do_req(1'b0, 32'h40, 4'b1111, 32'h0, 32'h0, rd, er, lat);
      chk("abort_word_zero", rd, 32'h0);
      chk("abort_err", 32'(er), 32'd0);
      do_req(1'b0, 32'h10, 4'b1111, 32'h0, 32'h0, rd, er, lat);
      chk("reset_cleared_array", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_bus_responder.md
Name: dm_bus_responder

Overview:
- Data-memory responder for the pipelined core's M-stage load/store traffic over a valid/ready request–response handshake.
- Replaces the single-cycle combinational data memory, so M-stage stalls can be exercised with programmable latency.
- Holds a word-addressed array with byte-lane writes and address error detection.
- Sits between the core's M stage (initiator) and the top level.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words (byte range 0x0000–0x2FFF).
- WAIT_CYCLES, 2, extra cycles between request accept and response (0–15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_be  in  4  byte enables; bit i selects bits [8i+7:8i].
- req_wdata  in  32  store data, lane-aligned.
- req_pc  in  32  PC of the issuing instruction, for the write trace.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load data: full word, lanes unmasked.
- rsp_err  out  1  request was out of range or had an illegal enable pattern.

Behaviour:
- Reset, synchronous:
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - All DEPTH_WORDS entries cleared to 0 in the same edge.
- Reset mid-operation aborts any pending request. A store that has not yet committed is discarded.
- State machine:
  - IDLE: req_ready = 1. On req_valid=1, latch we/addr/be/wdata/pc and set counter = WAIT_CYCLES. Go to WAIT if WAIT_CYCLES > 0, else to RESP.
  - WAIT: req_ready = 0. Decrement counter each cycle. On the edge where counter == 1, go to RESP.
  - RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable. On rsp_ready=1, go to IDLE.
- The edge that enters RESP is the commit edge:
  - A load samples the array word into rsp_rdata.
  - A store writes the enabled lanes and sets rsp_rdata = 0.
- Latency: a request accepted at edge N gives rsp_valid high from cycle N+1+WAIT_CYCLES.
  - With WAIT_CYCLES=0, rsp_valid rises the cycle after accept.
- Throughput:
  - req_ready is low in WAIT and RESP.
  - After the response handshake, req_ready returns high the following cycle. No request/response overlap, at most one outstanding request.
  - The minimum request-to-request spacing is 2+WAIT_CYCLES cycles.
- Error detection, evaluated on the latched request:
  - word index = addr[31:2]. Error if the index ≥ DEPTH_WORDS.
  - Error if be is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - On error: no array write, rsp_rdata = 0, rsp_err = 1.
  - addr[1:0] is ignored; the initiator aligns its lanes.
- be = 0000 is an error on a store. On a load it is treated as 1111.
- Write trace: on each successful commit of a store, emit a simulation-only display line.
  - Format: "@<pc>: *<word-aligned addr> <= <merged word>", all values 8-digit hex.
  - The merged word is the full post-write word.
- rsp_valid deasserted with no rsp_ready: illegal initiator behaviour. The responder must hold all outputs regardless.
- req_valid while req_ready = 0 is ignored. It is not queued.

Decomposition:
- Shared package holds:
  - State encoding constants IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - The legal byte-enable pattern list.
  - The default DEPTH_WORDS.
- One natural sub-module, dm_lane_merge: combinational merge of old word, wdata and be into the new word. It is reused by a future sub-word load/store extender.

Test Plan:
- Reset, then store addr 0x0000_0010, be=1111, wdata=0x1234_5678, WAIT=2 → rsp_valid rises 3 cycles after accept, rsp_err=0, trace "@00003000: *00000010 <= 12345678". A subsequent load of 0x10 returns 0x1234_5678.
- Store be=0010, wdata=0x0000_AB00 to word 0x10 (holding 0x1234_5678) → a load returns 0x1234_AB78.
- Load addr 0x0000_3000 (index 3072) → rsp_err=1, rsp_rdata=0. Store to 0x3000 → rsp_err=1, array unchanged.
- Store with be=0101 → rsp_err=1, target word unchanged.
- WAIT_CYCLES=0: back-to-back requests with rsp_ready held 1 → req_ready pattern 1,0,1,0; each response arrives 1 cycle after accept.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_err stay stable. Assert reset during WAIT of a pending store → no trace, word stays 0, rsp_valid=0 next cycle.
